// File: rtl/adder_arbiter.sv
// Round-robin scheduler that shares one fixed-latency adder among NUM_REQ operand requesters.
// Define ADDER_ARB_STATS_EN to add saturating per-requester grant counters and the stat_sel_i/stat_cnt_o ports.
module adder_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int ADDER_LAT = 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       en_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b_i,
    output logic [WIDTH-1:0]           add_a_o,
    output logic [WIDTH-1:0]           add_b_o,
    output logic                       add_vld_o,
    input  logic [WIDTH-1:0]           add_res_i,
    output logic [NUM_REQ-1:0]         rsp_valid_o,
    output logic [WIDTH-1:0]           rsp_data_o,
`ifdef ADDER_ARB_STATS_EN
    input  logic [$clog2(NUM_REQ)-1:0] stat_sel_i,
    output logic [31:0]                stat_cnt_o,
`endif
    output logic                       busy_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    // Handshake: a requester transfers in the cycle where req_valid_i[i] and
    // req_ready_o[i] are both high; ready is never raised without valid, and
    // responses are pulses that the requester must accept unconditionally.

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_found;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;

    always_comb begin
        gnt_idx   = '0;
        gnt_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            logic [PTR_W:0] cand;
            cand = {1'b0, ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!gnt_found && en_i && req_valid_i[cand[PTR_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_onehot = '0;
        sel_a      = '0;
        sel_b      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_found && (gnt_idx == PTR_W'(i))) begin
                gnt_onehot[i] = 1'b1;
                sel_a         = req_a_i[i*WIDTH +: WIDTH];
                sel_b         = req_b_i[i*WIDTH +: WIDTH];
            end
        end
    end

    assign req_ready_o = gnt_onehot;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr       <= '0;
            add_a_o   <= '0;
            add_b_o   <= '0;
            add_vld_o <= 1'b0;
        end else begin
            add_vld_o <= gnt_found;
            if (gnt_found) begin
                add_a_o <= sel_a;
                add_b_o <= sel_b;
                if (gnt_idx == PTR_W'(NUM_REQ - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= gnt_idx + PTR_W'(1);
                end
            end
        end
    end

    // Tag stage 0 lines up with add_vld_o; stage ADDER_LAT lines up with add_res_i.
    logic [ADDER_LAT:0] tag_vld;
    logic [PTR_W-1:0]   tag_id [ADDER_LAT+1];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tag_vld <= '0;
            for (int s = 0; s <= ADDER_LAT; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            tag_vld   <= {tag_vld[ADDER_LAT-1:0], gnt_found};
            tag_id[0] <= gnt_idx;
            for (int s = 1; s <= ADDER_LAT; s++) begin
                tag_id[s] <= tag_id[s-1];
            end
        end
    end

    logic [NUM_REQ-1:0] rsp_onehot;

    always_comb begin
        rsp_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tag_vld[ADDER_LAT] && (tag_id[ADDER_LAT] == PTR_W'(i))) begin
                rsp_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rsp_valid_o <= '0;
            rsp_data_o  <= '0;
        end else begin
            rsp_valid_o <= rsp_onehot;
            if (tag_vld[ADDER_LAT]) begin
                rsp_data_o <= add_res_i;
            end
        end
    end

    assign busy_o = |tag_vld;

`ifdef ADDER_ARB_STATS_EN
    logic [31:0] grant_cnt [NUM_REQ];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt_onehot[i] && (grant_cnt[i] != 32'hFFFF_FFFF)) begin
                    grant_cnt[i] <= grant_cnt[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        stat_cnt_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (stat_sel_i == PTR_W'(i)) begin
                stat_cnt_o = grant_cnt[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed steps plus random traffic against a round-robin/queue reference model.
// Stats checks are compiled in when ADDER_ARB_STATS_EN is defined.
module tb_adder_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int LAT = 1;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic           en_i;
    logic [N-1:0]   req_valid_i;
    logic [N-1:0]   req_ready_o;
    logic [N*W-1:0] req_a_i;
    logic [N*W-1:0] req_b_i;
    logic [W-1:0]   add_a_o;
    logic [W-1:0]   add_b_o;
    logic           add_vld_o;
    logic [W-1:0]   add_res_i;
    logic [N-1:0]   rsp_valid_o;
    logic [W-1:0]   rsp_data_o;
    logic           busy_o;
`ifdef ADDER_ARB_STATS_EN
    logic [1:0]     stat_sel_i;
    logic [31:0]    stat_cnt_o;
`endif

    adder_arbiter #(.NUM_REQ(N), .WIDTH(W), .ADDER_LAT(LAT)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .en_i        (en_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .add_a_o     (add_a_o),
        .add_b_o     (add_b_o),
        .add_vld_o   (add_vld_o),
        .add_res_i   (add_res_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
`ifdef ADDER_ARB_STATS_EN
        .stat_sel_i  (stat_sel_i),
        .stat_cnt_o  (stat_cnt_o),
`endif
        .busy_o      (busy_o)
    );

    // clock / reset block
    always #5 clk_i = ~clk_i;

    // adder environment: one-cycle registered sum of the issued operands
    always @(posedge clk_i) add_res_i <= add_a_o + add_b_o;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int           due_q[$];
    int           req_q[$];
    int           mptr;
    logic         m_add_vld;
    logic [W-1:0] m_add_a, m_add_b, m_rsp_data;
    int           m_cnt [N];
    int           cyc;
    int           total;
    int           bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        due_q.delete();
        req_q.delete();
        mptr       = 0;
        m_add_vld  = 1'b0;
        m_add_a    = '0;
        m_add_b    = '0;
        m_rsp_data = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        cyc++;
        reset_i     = 1'b1;
        en_i        = 1'b0;
        req_valid_i = '0;
        #1;
        model_clear();
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_data",  32'(rsp_data_o), 32'd0);
        chk("rst_add_a",     32'(add_a_o), 32'd0);
        chk("rst_add_b",     32'(add_b_o), 32'd0);
        chk("rst_add_vld",   32'(add_vld_o), 32'd0);
        chk("rst_busy",      32'(busy_o), 32'd0);
`ifdef ADDER_ARB_STATS_EN
        for (int i = 0; i < N; i++) begin
            stat_sel_i = 2'(i);
            #1;
            chk("rst_stat", stat_cnt_o, 32'd0);
        end
`endif
        @(negedge clk_i);
        cyc++;
        reset_i = 1'b0;
    endtask

    // driver + checker for one cycle
    task automatic step(input logic en, input logic [N-1:0] vld, input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        int           g;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        logic         exp_busy;
        @(negedge clk_i);
        cyc++;
        en_i        = en;
        req_valid_i = vld;
        req_a_i     = a;
        req_b_i     = b;
        #1;
        g = -1;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (mptr + k) % N;
                if (g < 0 && vld[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("ready", 32'(req_ready_o), 32'(exp_rdy));
        chk("add_vld", 32'(add_vld_o), 32'(m_add_vld));
        chk("add_a", 32'(add_a_o), 32'(m_add_a));
        chk("add_b", 32'(add_b_o), 32'(m_add_b));

        exp_busy = 1'b0;
        foreach (due_q[j]) if (due_q[j] == cyc + 1 || due_q[j] == cyc + 2) exp_busy = 1'b1;
        chk("busy", 32'(busy_o), 32'(exp_busy));

        exp_rv = '0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            exp_rv[req_q[0]] = 1'b1;
            m_rsp_data       = exp_q[0];
            void'(due_q.pop_front());
            void'(req_q.pop_front());
            void'(exp_q.pop_front());
        end
        chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_rv));
        chk("rsp_data", 32'(rsp_data_o), 32'(m_rsp_data));

        if (g >= 0) begin
            m_add_vld = 1'b1;
            m_add_a   = a[g*W +: W];
            m_add_b   = b[g*W +: W];
            exp_q.push_back(W'((int'(m_add_a) + int'(m_add_b)) % 256));
            due_q.push_back(cyc + 2 + LAT);
            req_q.push_back(g);
            mptr = (g + 1) % N;
            m_cnt[g]++;
        end else begin
            m_add_vld = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, '0, '0, '0);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        cyc         = 0;
        reset_i     = 1'b1;
        en_i        = 1'b0;
        req_valid_i = '0;
        req_a_i     = '0;
        req_b_i     = '0;
`ifdef ADDER_ARB_STATS_EN
        stat_sel_i  = '0;
`endif
        do_reset();
        idle(2);

        // single requester 2: 3 + 4
        step(1'b1, 4'b0100, 32'h0003_0000, 32'h0004_0000);
        idle(4);
        chk("sum_3_4", 32'(rsp_data_o), 32'd7);

        // wrap: 200 + 100 on requester 0
        step(1'b1, 4'b0001, 32'h0000_00C8, 32'h0000_0064);
        idle(4);
        chk("wrap_sum", 32'(rsp_data_o), 32'd44);

        // all four valid continuously from reset
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 4'hF, $urandom, $urandom);
        idle(4);

        // en_i dropped for three cycles while all are valid
        for (int i = 0; i < 2; i++) step(1'b1, 4'hF, $urandom, $urandom);
        for (int i = 0; i < 3; i++) step(1'b0, 4'hF, $urandom, $urandom);
        for (int i = 0; i < 5; i++) step(1'b1, 4'hF, $urandom, $urandom);
        idle(4);

        // reset one cycle after a grant: that issue must never respond
        step(1'b1, 4'b0010, 32'h0000_1100, 32'h0000_2200);
        do_reset();
        idle(4);
        step(1'b1, 4'hF, $urandom, $urandom);
        idle(4);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 7) != 0), 4'($urandom_range(0, 15)), $urandom, $urandom);
        end
        idle(5);
        chk("pending", 32'(exp_q.size()), 32'd0);

`ifdef ADDER_ARB_STATS_EN
        // directed stats: 5 grants to req 1, 2 to req 3
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 4'b0010, $urandom, $urandom);
        for (int i = 0; i < 2; i++) step(1'b1, 4'b1000, $urandom, $urandom);
        idle(4);
        for (int i = 0; i < N; i++) begin
            stat_sel_i = 2'(i);
            #1;
            chk("stat_cnt", stat_cnt_o, 32'(m_cnt[i]));
        end
        stat_sel_i = 2'd1;
        #1;
        chk("stat_req1", stat_cnt_o, 32'd5);
        stat_sel_i = 2'd3;
        #1;
        chk("stat_req3", stat_cnt_o, 32'd2);
        do_reset();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin scheduler that shares one fixed-latency WIDTH-bit adder datapath (the `bfm` adder instance) among NUM_REQ operand requesters. Each requester presents an A/B operand pair with a valid/ready handshake. The arbiter grants at most one pair per cycle and drives the registered operands into the adder. It tags each issued pair through a latency-matched pipeline and returns the adder result to the originating requester as a one-cycle response pulse. It replaces direct operand streaming from the testbench wrapper when several stimulus sources share the adder.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- WIDTH, 8, operand/result width
- ADDER_LAT, 1, cycles from adder operands registered to `add_res_i` valid (≥1)
- clk_i  in  1  clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- en_i  in  1  grant enable; low = no new grants, in-flight work drains
- req_valid_i  in  NUM_REQ  per-requester operand valid
- req_ready_o  out  NUM_REQ  per-requester grant (one-hot or zero)
- req_a_i  in  NUM_REQ*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH]
- req_b_i  in  NUM_REQ*WIDTH  operand B; same packing as `req_a_i`
- add_a_o  out  WIDTH  registered operand A to adder
- add_b_o  out  WIDTH  registered operand B to adder
- add_vld_o  out  1  operands on `add_a_o`/`add_b_o` are a new issue
- add_res_i  in  WIDTH  adder result, mod 2^WIDTH
- rsp_valid_o  out  NUM_REQ  one-hot response pulse to the originating requester
- rsp_data_o  out  WIDTH  response sum, shared bus
- busy_o  out  1  any issue in flight
- Stats ports, present only with ADDER_ARB_STATS_EN:
  - stat_sel_i  in  $clog2(NUM_REQ)  counter select
  - stat_cnt_o  out  32  grant count of the selected requester, combinational read

## Operation
- Round-robin pointer `ptr`; reset value 0.
- Each cycle with en_i=1, the grant goes to the first i with req_valid_i[i]=1, scanning ptr, ptr+1, … modulo NUM_REQ.
- `req_ready_o` is combinational from `req_valid_i`, `ptr` and `en_i`. It is never asserted for a non-valid requester.
- Transfer occurs when req_valid_i[i] & req_ready_o[i].
- On transfer, ptr ← (i+1) mod NUM_REQ. With no transfer, ptr is held.
- On transfer at edge e:
  - add_a_o/add_b_o ← requester i's operands.
  - add_vld_o ← 1.
  - Tag {valid, i} enters the tag pipeline.
- With no transfer, add_a_o/add_b_o hold their value and add_vld_o ← 0.
- The tag pipeline is ADDER_LAT+1 stages deep. When a valid tag reaches the output stage:
  - rsp_valid_o[tag] = 1 for one cycle.
  - rsp_data_o = add_res_i, registered.
- Responses have no backpressure. Requesters must accept them.
- busy_o = OR of all tag-pipeline valid bits.
- en_i deassertion does not affect in-flight tags; they complete normally.
- Requester valid/operands may change freely while not granted.
- A requester granted back-to-back keeps its order: responses return in issue order.
- Reset (any time, asynchronous) forces:
  - ptr=0, all tags invalid, add_a_o=add_b_o=0, add_vld_o=0.
  - rsp_valid_o=0, rsp_data_o=0, busy_o=0, stats counters=0.
- In-flight issues are discarded on reset; no response is produced for them.

## Timing
- Handshake in cycle c → add_vld_o=1 in cycle c+1 → add_res_i valid in cycle c+1+ADDER_LAT → rsp_valid_o in cycle c+2+ADDER_LAT.
- With the default ADDER_LAT=1, a grant in cycle c gives rsp_valid_o in cycle c+3.
- Throughput: one issue per cycle, sustained.
- Worst-case wait for a continuously valid requester: NUM_REQ-1 cycles.
- Sums wrap mod 2^WIDTH; no carry-out.

## Configuration
- ADDER_ARB_STATS_EN defined:
  - One 32-bit grant counter per requester, incremented on each transfer.
  - Counters saturate at 2^32-1.
  - `stat_sel_i`/`stat_cnt_o` ports exist.
- ADDER_ARB_STATS_EN undefined: no counters and no stats ports. All other behaviour is identical.

## Test plan
- Single requester: req 2 sends A=3, B=4 at cycle 5 → req_ready_o=4'b0100 in cycle 5, add_a_o=3/add_b_o=4 with add_vld_o in cycle 6, rsp_valid_o=4'b0100 with rsp_data_o=7 in cycle 8.
- All four requesters valid continuously from reset → grant order 0,1,2,3,0,…; one response per cycle from cycle 3 in the same order.
- Wrap: A=200, B=100 → rsp_data_o=44.
- en_i dropped for 3 cycles while all requesters are valid → no ready during those cycles; earlier issues still respond; ptr unchanged; resumes with the next requester in order.
- reset_i pulsed one cycle after a grant → no rsp_valid_o for that issue; all outputs 0; next grant goes to requester 0 first.
- With ADDER_ARB_STATS_EN: 5 grants to req 1 and 2 to req 3 → stat_sel_i=1 reads 5, stat_sel_i=3 reads 2; reset clears both to 0.
